// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants for the instruction/data memory access controller:
// default widths, latency and the per-channel FSM state encoding.
package mem_access_ctrl_pkg;
  localparam int WORD_SIZE_DEF   = 16;
  localparam int MEM_LATENCY_DEF = 2;
  localparam int CNT_W           = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_HOLD   = 2'd2
  } ch_state_e;
endpackage

// File: rtl/mem_latency_fsm.sv
// Per-channel access sequencer: counts LATENCY cycles per access and reports
// first/active/done/busy for the current cycle; state is exposed on o_state.
module mem_latency_fsm
  import mem_access_ctrl_pkg::*;
#(
  parameter int LATENCY  = MEM_LATENCY_DEF,
  parameter bit HAS_HOLD = 1'b0
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      i_req,
  input  logic      i_hit,
  input  logic      i_restart,
  input  logic      i_abort,
  output logic      o_first,
  output logic      o_active,
  output logic      o_done,
  output logic      o_busy,
  output ch_state_e o_state
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LATENCY - 1);

  ch_state_e        r_state;
  ch_state_e        w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic [CNT_W-1:0] w_cnt_cur;
  logic             w_start;
  logic             w_restart;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Everything is gated by reset_n so strobes and busy drop in the reset cycle.
  always_comb begin
    w_start      = reset_n && i_req &&
                   ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && !i_hit));
    w_restart    = reset_n && (r_state == ST_ACCESS) && i_restart;
    o_first      = w_start || w_restart;
    o_active     = w_start || (reset_n && (r_state == ST_ACCESS));
    w_cnt_cur    = o_first ? '0 : r_cnt;
    o_done       = o_active && (w_cnt_cur == LAST);
    o_busy       = o_active && !o_done;
    w_next_state = r_state;
    w_next_cnt   = '0;
    if (o_active) begin
      if (i_abort) begin
        w_next_state = ST_IDLE;
      end else if (o_done) begin
        w_next_state = HAS_HOLD ? ST_HOLD : ST_IDLE;
      end else begin
        w_next_state = ST_ACCESS;
        w_next_cnt   = w_cnt_cur + CNT_W'(1);
      end
    end
  end

  assign o_state = r_state;
endmodule

// File: rtl/mem_access_ctrl.sv
// Instruction/data memory access controller: two independent latency FSMs,
// plus a one-entry hold buffer that serves repeated fetches of the same address.
// Handshake: a requester keeps its request and operands steady while busy=1;
// the access completes in the first cycle the request is present with busy=0.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int WORD_SIZE   = WORD_SIZE_DEF,
  parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  input  logic                 i_abort,
  output logic [WORD_SIZE-1:0] i_data,
  output logic                 i_busy,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_busy,
  output logic                 i_mem_read,
  output logic [WORD_SIZE-1:0] i_mem_addr,
  input  logic [WORD_SIZE-1:0] i_mem_data,
  output logic                 d_mem_read,
  output logic                 d_mem_write,
  output logic [WORD_SIZE-1:0] d_mem_addr,
  output logic [WORD_SIZE-1:0] d_mem_wdata,
  input  logic [WORD_SIZE-1:0] d_mem_rdata
);
  logic                 w_i_first, w_i_active, w_i_done, w_i_busy;
  logic                 w_i_hit, w_i_restart;
  ch_state_e            w_i_state;
  logic [WORD_SIZE-1:0] r_i_acc_addr;
  logic [WORD_SIZE-1:0] r_i_buf_addr;
  logic [WORD_SIZE-1:0] r_i_buf_data;
  logic                 r_i_buf_valid;

  logic                 w_d_first, w_d_active, w_d_done, w_d_busy;
  logic                 w_d_in_access, w_d_wr;
  ch_state_e            w_d_state;
  logic                 r_d_wr;
  logic [WORD_SIZE-1:0] r_d_addr;
  logic [WORD_SIZE-1:0] r_d_wdata;
  logic [WORD_SIZE-1:0] r_d_rdata;

  assign w_i_restart = (i_addr != r_i_acc_addr);
  assign w_i_hit     = (w_i_state == ST_HOLD) && r_i_buf_valid && i_req && !i_abort &&
                       (i_addr == r_i_buf_addr);

  mem_latency_fsm #(.LATENCY(MEM_LATENCY), .HAS_HOLD(1'b1)) u_i_fsm (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_req     (i_req),
    .i_hit     (w_i_hit),
    .i_restart (w_i_restart),
    .i_abort   (i_abort),
    .o_first   (w_i_first),
    .o_active  (w_i_active),
    .o_done    (w_i_done),
    .o_busy    (w_i_busy),
    .o_state   (w_i_state)
  );

  assign i_mem_read = w_i_active;
  assign i_mem_addr = w_i_first ? i_addr : r_i_acc_addr;
  assign i_busy     = w_i_busy;
  // The buffer data is also the last completed fetch value.
  assign i_data     = w_i_done ? i_mem_data : r_i_buf_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_i_acc_addr  <= '0;
      r_i_buf_addr  <= '0;
      r_i_buf_data  <= '0;
      r_i_buf_valid <= 1'b0;
    end else begin
      if (w_i_first) r_i_acc_addr <= i_addr;
      if (w_i_done && !i_abort) begin
        r_i_buf_addr  <= i_mem_addr;
        r_i_buf_data  <= i_mem_data;
        r_i_buf_valid <= 1'b1;
      end else if (w_i_first && (w_i_state == ST_ACCESS)) begin
        r_i_buf_valid <= 1'b0;
      end
    end
  end

  mem_latency_fsm #(.LATENCY(MEM_LATENCY), .HAS_HOLD(1'b0)) u_d_fsm (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_req     (d_read | d_write),
    .i_hit     (1'b0),
    .i_restart (1'b0),
    .i_abort   (1'b0),
    .o_first   (w_d_first),
    .o_active  (w_d_active),
    .o_done    (w_d_done),
    .o_busy    (w_d_busy),
    .o_state   (w_d_state)
  );

  // Write wins when both read and write are requested.
  assign w_d_in_access = (w_d_state == ST_ACCESS);
  assign w_d_wr        = w_d_in_access ? r_d_wr : d_write;
  assign d_mem_write   = w_d_active && w_d_wr;
  assign d_mem_read    = w_d_active && !w_d_wr;
  assign d_mem_addr    = w_d_in_access ? r_d_addr : d_addr;
  assign d_mem_wdata   = w_d_in_access ? r_d_wdata : d_wdata;
  assign d_busy        = w_d_busy;
  assign d_rdata       = (w_d_done && !w_d_wr) ? d_mem_rdata : r_d_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_d_wr    <= 1'b0;
      r_d_addr  <= '0;
      r_d_wdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (w_d_first) begin
        r_d_wr    <= d_write;
        r_d_addr  <= d_addr;
        r_d_wdata <= d_wdata;
      end
      if (w_d_done && !w_d_wr) r_d_rdata <= d_mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: random fetch/load/store traffic on both channels,
// expected responses queued by a reference model and checked by a negedge monitor.
module tb_mem_access_ctrl;
  localparam int LAT = 2;

  logic        clk;
  logic        reset_n;
  logic        i_req, i_abort;
  logic [15:0] i_addr, i_data;
  logic        i_busy;
  logic        d_read, d_write, d_busy;
  logic [15:0] d_addr, d_wdata, d_rdata;
  logic        i_mem_read, d_mem_read, d_mem_write;
  logic [15:0] i_mem_addr, i_mem_data;
  logic [15:0] d_mem_addr, d_mem_wdata, d_mem_rdata;

  mem_access_ctrl #(.WORD_SIZE(16), .MEM_LATENCY(LAT)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_abort     (i_abort),
    .i_data      (i_data),
    .i_busy      (i_busy),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_busy      (d_busy),
    .i_mem_read  (i_mem_read),
    .i_mem_addr  (i_mem_addr),
    .i_mem_data  (i_mem_data),
    .d_mem_read  (d_mem_read),
    .d_mem_write (d_mem_write),
    .d_mem_addr  (d_mem_addr),
    .d_mem_wdata (d_mem_wdata),
    .d_mem_rdata (d_mem_rdata)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory environment ----------------
  function automatic logic [15:0] imem_f(input logic [15:0] a);
    return (a * 16'd3) ^ 16'h6001;
  endfunction

  logic [15:0] phys    [16];
  logic [15:0] ref_mem [16];

  assign i_mem_data  = imem_f(i_mem_addr);
  assign d_mem_rdata = phys[d_mem_addr[7:4]];

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  logic [19:0] i_exp_q[$];   // {strobe, busy_cycles[2:0], data}
  logic [32:0] d_exp_q[$];   // {is_write, addr, data}

  logic [15:0] m_held;
  bit          m_held_ok;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic i_fetch(input logic [15:0] a);
    bit hit;
    hit = m_held_ok && (a == m_held);
    i_exp_q.push_back({!hit, (hit ? 3'd0 : 3'(LAT - 1)), imem_f(a)});
    i_req = 1'b1; i_addr = a; i_abort = 1'b0;
    m_held = a; m_held_ok = 1'b1;
    cyc(hit ? 1 : LAT);
  endtask

  // a must never be the held address, so its cycle is always an access start
  task automatic i_change_addr(input logic [15:0] a, input logic [15:0] b);
    i_exp_q.push_back({1'b1, 3'(LAT), imem_f(b)});
    i_req = 1'b1; i_addr = a; i_abort = 1'b0;
    cyc(1);
    i_addr = b;
    m_held = b; m_held_ok = 1'b1;
    cyc(LAT);
  endtask

  task automatic i_abort_then(input logic [15:0] a, input logic [15:0] b);
    i_req = 1'b1; i_addr = a; i_abort = 1'b1;
    cyc(1);
    i_abort = 1'b0;
    m_held_ok = 1'b0;
    i_fetch(b);
  endtask

  task automatic i_idle(input int n);
    i_req = 1'b0;
    cyc(n);
  endtask

  // op: 0 read, 1 write, 2 read+write (write expected)
  task automatic d_access(input int op, input logic [15:0] a, input logic [15:0] wd);
    bit wr;
    wr = (op != 0);
    d_exp_q.push_back({wr, a, (wr ? wd : ref_mem[a[7:4]])});
    if (wr) ref_mem[a[7:4]] = wd;
    d_read = (op != 1); d_write = (op != 0); d_addr = a; d_wdata = wd;
    cyc(LAT);
  endtask

  task automatic d_idle(input int n);
    d_read = 1'b0; d_write = 1'b0;
    cyc(n);
  endtask

  // ---------------- monitor ----------------
  int          i_cnt = 0;
  int          d_cnt = 0;
  logic [19:0] i_e;
  logic [32:0] d_e;
  logic [15:0] d_first_addr, d_first_wdata;

  always @(negedge clk) begin
    if (mon_en) begin
      if (i_req && i_abort) begin
        i_cnt = 0;
      end else if (i_req && i_busy) begin
        i_cnt++;
      end else if (i_req) begin
        if (i_exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL i_unexpected: response 0x%0h with empty queue, expected none", i_data);
        end else begin
          i_e = i_exp_q.pop_front();
          chk("i_mem_read", 32'(i_mem_read), 32'(i_e[19]));
          chk("i_busy_cycles", 32'(i_cnt), 32'(i_e[18:16]));
          chk("i_data", 32'(i_data), 32'(i_e[15:0]));
        end
        i_cnt = 0;
      end

      if (d_mem_read || d_mem_write) begin
        if (d_cnt == 0) begin
          d_first_addr  = d_mem_addr;
          d_first_wdata = d_mem_wdata;
        end
        d_cnt++;
        if (!d_busy) begin
          if (d_exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL d_unexpected: completion at 0x%0h with empty queue, expected none", d_mem_addr);
          end else begin
            d_e = d_exp_q.pop_front();
            chk("d_is_write", 32'(d_mem_write), 32'(d_e[32]));
            chk("d_addr", 32'(d_mem_addr), 32'(d_e[31:16]));
            chk("d_addr_stable", 32'(d_first_addr), 32'(d_e[31:16]));
            chk("d_strobe_cycles", 32'(d_cnt), 32'(LAT));
            if (d_e[32]) begin
              chk("d_wdata", 32'(d_mem_wdata), 32'(d_e[15:0]));
              chk("d_wdata_stable", 32'(d_first_wdata), 32'(d_e[15:0]));
              phys[d_mem_addr[7:4]] = d_mem_wdata;
            end else begin
              chk("d_rdata", 32'(d_rdata), 32'(d_e[15:0]));
            end
          end
          d_cnt = 0;
        end
      end else begin
        chk("d_busy_idle", 32'(d_busy), 32'(0));
      end
    end
  end

  // ---------------- main sequence ----------------
  task automatic chk_all_zero(input string tag);
    chk({tag, "_i_mem_read"}, 32'(i_mem_read), 32'(0));
    chk({tag, "_d_mem_read"}, 32'(d_mem_read), 32'(0));
    chk({tag, "_d_mem_write"}, 32'(d_mem_write), 32'(0));
    chk({tag, "_i_busy"}, 32'(i_busy), 32'(0));
    chk({tag, "_d_busy"}, 32'(d_busy), 32'(0));
    chk({tag, "_i_data"}, 32'(i_data), 32'(0));
    chk({tag, "_d_rdata"}, 32'(d_rdata), 32'(0));
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      phys[k]    = 16'h1000 + 16'(k);
      ref_mem[k] = 16'h1000 + 16'(k);
    end
    m_held = '0; m_held_ok = 1'b0;
    reset_n = 1'b0;
    // requests held high during reset must not leak onto the strobes
    i_req = 1'b1; i_addr = 16'h0123; i_abort = 1'b0;
    d_read = 1'b1; d_write = 1'b1; d_addr = 16'h0040; d_wdata = 16'h5555;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");

    @(posedge clk); #1;
    i_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
    reset_n = 1'b1;
    mon_en = 1'b1;
    cyc(1);

    fork
      begin
        i_fetch(16'h0000);
        repeat (3) i_fetch(16'h0000);
        i_abort_then(16'h0010, 16'h0020);
        for (int n = 0; n < 60; n++) begin
          int r;
          logic [15:0] a;
          r = $urandom_range(0, 9);
          a = 16'($urandom_range(0, 3)) << 4;
          if (r <= 5)      i_fetch(a);
          else if (r == 6) i_idle($urandom_range(1, 2));
          else if (r == 7) i_change_addr(16'h0100 | 16'($urandom_range(0, 255)), a);
          else if (r == 8) i_abort_then(a, 16'($urandom_range(0, 3)) << 4);
          else             i_fetch(m_held_ok ? m_held : a);
        end
        i_idle(1);
      end
      begin
        d_access(1, 16'h0040, 16'hBEEF);
        d_access(0, 16'h0050, 16'h0000);
        d_access(0, 16'h0050, 16'h0000);
        d_access(0, 16'h0040, 16'h0000);
        for (int n = 0; n < 60; n++) begin
          d_access($urandom_range(0, 2), 16'h0040 + (16'($urandom_range(0, 3)) << 4),
                   16'($urandom()));
          if ($urandom_range(0, 2) == 0) d_idle(1);
        end
        d_idle(1);
      end
    join

    for (int k = 0; k < 20 && (i_exp_q.size() != 0 || d_exp_q.size() != 0); k++) cyc(1);
    chk("i_queue_drained", 32'(i_exp_q.size()), 32'(0));
    chk("d_queue_drained", 32'(d_exp_q.size()), 32'(0));

    // reset asserted during access cycle 0 of both channels
    mon_en = 1'b0;
    cyc(1);
    i_req = 1'b1; i_addr = 16'h0200; i_abort = 1'b0;
    d_read = 1'b0; d_write = 1'b1; d_addr = 16'h0040; d_wdata = 16'h1234;
    #2;
    chk("pre_reset_i_busy", 32'(i_busy), 32'(1));
    chk("pre_reset_d_mem_write", 32'(d_mem_write), 32'(1));
    reset_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    cyc(2);
    chk_all_zero("held_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
